// File: rtl/crossy_lane_engine.sv
// crossy_lane_engine: multi-lane scrolling obstacle playfield with hop scroll,
// per-frame latched collision and an IDLE/PLAY/DEAD game FSM.
module crossy_lane_engine #(
    parameter int NUM_LANES   = 4,
    parameter int LANE_TOP    = 40,
    parameter int LANE_H      = 100,
    parameter int OB_W        = 180,
    parameter int X_STAGGER   = 160,
    parameter int SCREEN_W    = 640,
    parameter int CHICKEN_X   = 310,
    parameter int CHICKEN_Y   = 390,
    parameter int CHICKEN_W   = 30,
    parameter int CHICKEN_H   = 40,
    parameter int BASE_SPEED  = 1,
    parameter int MAX_LEVEL   = 4,
    parameter int DEAD_FRAMES = 60,
    parameter int TICK_LINE   = 480
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [9:0] i_hpos,
    input  logic [9:0] i_vpos,
    input  logic       i_display_on,
    input  logic       i_move_btn,
    output logic [2:0] o_rgb,
    output logic [6:0] o_score,
    output logic       o_game_over,
    output logic [1:0] o_state
);
    localparam logic [1:0] IDLE = 2'd0, PLAY = 2'd1, DEAD = 2'd2;
    logic [1:0] state, state_nx;
    logic [9:0] lane_x [NUM_LANES];
    logic [9:0] lane_mv [NUM_LANES];
    logic [NUM_LANES-1:0] obs_v;
    logic [15:0] lfsr;
    logic [6:0] score;
    logic [7:0] frame_cnt;
    logic [2:0] btn_s;
    logic [3:0] lvl;
    logic [9:0] seed_x;
    logic hit, hop_req, tick, btn_edge, hop, move, chick, obs, dead_done;
    always_comb begin
        tick = i_hpos == 10'd0 && i_vpos == 10'(TICK_LINE);
        btn_edge = btn_s[1] & ~btn_s[2];
        lvl = score[6:3] > 4'(MAX_LEVEL) ? 4'(MAX_LEVEL) : score[6:3];
        hop = state == PLAY && hop_req && !hit;
        move = state != DEAD && !hop;
        dead_done = frame_cnt == 8'(DEAD_FRAMES - 1);
        seed_x = lfsr[9:0] >= 10'(SCREEN_W) ? lfsr[9:0] - 10'(SCREEN_W) : lfsr[9:0];
        chick = i_hpos >= 10'(CHICKEN_X) && i_hpos < 10'(CHICKEN_X + CHICKEN_W) &&
                i_vpos >= 10'(CHICKEN_Y) && i_vpos < 10'(CHICKEN_Y + CHICKEN_H);
        obs = |obs_v;
    end
    // Speed and direction belong to the lane index; obstacles only carry x.
    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        logic [10:0] sp, fwd, bwd;
        logic [11:0] dd, d;
        assign sp = 11'(BASE_SPEED + k % 3) + 11'(lvl);
        assign fwd = {1'b0, lane_x[k]} + sp;
        assign bwd = {1'b0, lane_x[k]} - sp;
        assign lane_mv[k] = k % 2 == 0 ? 10'(fwd >= 11'(SCREEN_W) ? fwd - 11'(SCREEN_W) : fwd)
                                       : 10'(bwd[10] ? bwd + 11'(SCREEN_W) : bwd);
        assign dd = {2'b0, i_hpos} + 12'(SCREEN_W) - {2'b0, lane_x[k]};
        assign d = dd >= 12'(2 * SCREEN_W) ? dd - 12'(2 * SCREEN_W) :
                   dd >= 12'(SCREEN_W) ? dd - 12'(SCREEN_W) : dd;
        assign obs_v[k] = i_vpos >= 10'(LANE_TOP + k * LANE_H + 10) &&
                          i_vpos < 10'(LANE_TOP + (k + 1) * LANE_H - 10) && d < 12'(OB_W);
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = !tick ? state :
                   state == IDLE ? (hop_req ? PLAY : IDLE) :
                   state == PLAY ? (hit ? DEAD : PLAY) :
                   (dead_done ? IDLE : DEAD);
    end
    always_comb begin
        o_state = state;
        o_game_over = state == DEAD;
        o_score = score;
    end
    // In IDLE the pending request doubles as the start request.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_LANES; i++) lane_x[i] <= 10'((i * X_STAGGER) % SCREEN_W);
            lfsr <= 16'hACE1;
            score <= 7'd0;
            frame_cnt <= 8'd0;
            hit <= 1'b0;
            hop_req <= 1'b0;
            btn_s <= 3'd0;
            o_rgb <= 3'd0;
        end else begin
            btn_s <= {btn_s[1:0], i_move_btn};
            hop_req <= !tick && (hop_req || (btn_edge && state != DEAD));
            hit <= !tick && (hit || (state == PLAY && i_display_on && chick && obs));
            o_rgb <= !i_display_on ? 3'b000 :
                     (chick && !(state == DEAD && frame_cnt[3])) ? 3'b010 :
                     obs ? 3'b001 : 3'b100;
            if (tick) begin
                score <= (state == IDLE && hop_req) ? 7'd0 :
                         hop ? (score == 7'd99 ? score : score + 7'd1) : score;
                frame_cnt <= (state == DEAD && !dead_done) ? frame_cnt + 8'd1 : 8'd0;
                if (hop) begin
                    lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
                    lane_x[0] <= seed_x;
                    for (int i = 1; i < NUM_LANES; i++) lane_x[i] <= lane_x[i-1];
                end else if (move) begin
                    for (int i = 0; i < NUM_LANES; i++) lane_x[i] <= lane_mv[i];
                end
            end
        end
    end
endmodule

// File: tb/tb_crossy_lane_engine.sv
// tb_crossy_lane_engine: randomized pixel/button stimulus against a frame-level
// game model; a monitor pops expected colours and per-tick status from queues.
module tb_crossy_lane_engine;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [9:0] hpos = 10'd1, vpos = 10'd481;
    logic de = 1'b0, btn = 1'b0;
    logic [2:0] rgb;
    logic [6:0] score;
    logic go;
    logic [1:0] st;
    always #5 clk = ~clk;

    crossy_lane_engine dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_hpos(hpos), .i_vpos(vpos),
        .i_display_on(de), .i_move_btn(btn), .o_rgb(rgb), .o_score(score),
        .o_game_over(go), .o_state(st)
    );

    typedef struct packed {
        logic [1:0] st;
        logic [6:0] score;
        logic go;
        logic [3:0][9:0] lx;
    } status_t;

    logic [3:0][9:0] dut_lx;
    assign dut_lx = {dut.lane_x[3], dut.lane_x[2], dut.lane_x[1], dut.lane_x[0]};

    int checks = 0, failures = 0;
    int m_lx [4];
    int m_st, m_score, m_fcnt, ticks;
    bit m_req, m_hit;
    logic [15:0] m_lfsr;
    logic [2:0] q_pix [$];
    status_t q_st [$];
    status_t s_exp;
    logic probe = 1'b0, probe_d = 1'b0, tick_d = 1'b0;

    always @(posedge clk) begin
        probe_d <= probe;
        tick_d <= rst_n && hpos == 10'd0 && vpos == 10'd480;
    end

    task automatic check(input string n, input int a, input int e);
        checks++;
        if (a != e) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", n, a, e);
        end
    endtask

    always @(negedge clk) begin
        if (probe_d) begin
            if (q_pix.size() == 0) begin
                checks++; failures++;
                $display("FAIL rgb_queue_empty actual=%0d", rgb);
            end else check("rgb", int'(rgb), int'(q_pix.pop_front()));
        end
        if (tick_d) begin
            if (q_st.size() == 0) begin
                checks++; failures++;
                $display("FAIL status_queue_empty state=%0d", st);
            end else begin
                s_exp = q_st.pop_front();
                check("state", int'(st), int'(s_exp.st));
                check("score", int'(score), int'(s_exp.score));
                check("game_over", int'(go), int'(s_exp.go));
                for (int k = 0; k < 4; k++) check($sformatf("lane_x%0d", k), int'(dut_lx[k]), int'(s_exp.lx[k]));
            end
        end
    end

    function automatic bit is_chick(int h, int v);
        return h >= 310 && h < 340 && v >= 390 && v < 430;
    endfunction

    function automatic bit m_obs(int h, int v);
        int k, off;
        if (v < 40 || v >= 440) return 0;
        k = (v - 40) / 100;
        off = (v - 40) % 100;
        if (off < 10 || off >= 90) return 0;
        return (((h - m_lx[k]) % 640) + 640) % 640 < 180;
    endfunction

    function automatic logic [2:0] m_rgb(int h, int v, bit d);
        if (!d) return 3'b000;
        if (is_chick(h, v) && !(m_st == 2 && (m_fcnt & 8) != 0)) return 3'b010;
        if (m_obs(h, v)) return 3'b001;
        return 3'b100;
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 4; k++) m_lx[k] = (k * 160) % 640;
        m_lfsr = 16'hACE1;
        m_score = 0; m_st = 0; m_fcnt = 0; m_req = 0; m_hit = 0; ticks = 0;
    endtask

    task automatic m_tick();
        int lvl;
        status_t s;
        lvl = (m_score / 8 > 4) ? 4 : m_score / 8;
        if (m_st == 2) begin
            if (m_fcnt == 59) begin m_st = 0; m_fcnt = 0; end
            else m_fcnt++;
        end else if (m_st == 1 && m_req && !m_hit) begin
            for (int k = 3; k > 0; k--) m_lx[k] = m_lx[k-1];
            m_lx[0] = int'(m_lfsr[9:0]) % 640;
            m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
            m_score = m_score == 99 ? 99 : m_score + 1;
        end else begin
            for (int k = 0; k < 4; k++) begin
                int sp;
                sp = 1 + k % 3 + lvl;
                m_lx[k] = (k % 2 == 0) ? (m_lx[k] + sp) % 640 : (m_lx[k] - sp + 640) % 640;
            end
            if (m_st == 0 && m_req) begin m_st = 1; m_score = 0; end
            else if (m_st == 1 && m_hit) m_st = 2;
        end
        m_req = 0; m_hit = 0;
        s.st = 2'(m_st); s.score = 7'(m_score); s.go = m_st == 2;
        for (int k = 0; k < 4; k++) s.lx[k] = 10'(m_lx[k]);
        q_st.push_back(s);
    endtask

    task automatic drive(input int h, input int v, input bit d, input bit p, input bit b);
        @(posedge clk);
        #1;
        hpos = 10'(h); vpos = 10'(v); de = d; probe = p; btn = b;
        if (p) begin
            q_pix.push_back(m_rgb(h, v, d));
            if (m_st == 1 && d && is_chick(h, v) && m_obs(h, v)) m_hit = 1;
        end
    endtask

    task automatic rand_probe(input bit avoid, input bit b);
        int h, v;
        do begin
            h = $urandom_range(0, 799);
            v = $urandom_range(0, 524);
        end while ((h == 0 && v == 480) || (avoid && is_chick(h, v)));
        drive(h, v, h < 640 && v < 480, 1, b);
    endtask

    task automatic tick_frame(input int presses, input bit chick_mode);
        for (int p = 0; p < presses; p++) begin
            if (m_st != 2) m_req = 1;
            repeat (4) rand_probe(!chick_mode, 1);
            repeat (4) rand_probe(!chick_mode, 0);
        end
        repeat (3) rand_probe(!chick_mode, 0);
        if (chick_mode) begin
            drive(339, 400, 1, 1, 0);
            repeat (2) drive($urandom_range(310, 339), $urandom_range(390, 429), 1, 1, 0);
        end
        drive(0, 480, 0, 0, 0);
        @(posedge clk);
        #1;
        m_tick();
        ticks++;
        hpos = 10'd1; vpos = 10'd481; de = 1'b0; probe = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        probe = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check({tag, "_rgb"}, int'(rgb), 0);
        check({tag, "_score"}, int'(score), 0);
        check({tag, "_state"}, int'(st), 0);
        check({tag, "_game_over"}, int'(go), 0);
        for (int k = 0; k < 4; k++) check($sformatf("%s_lane%0d", tag, k), int'(dut_lx[k]), k * 160);
        m_reset();
        q_pix.delete();
        q_st.delete();
        hpos = 10'd1; vpos = 10'd481; de = 1'b0; btn = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout checks=%0d", checks);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int guard, death_tick, dead_ticks, old0;
        int old [4];
        m_reset();
        #12;
        check("por_rgb", int'(rgb), 0);
        check("por_state", int'(st), 0);
        check("por_score", int'(score), 0);
        #11 rst_n = 1'b1;

        for (int f = 0; f < 10; f++) begin
            drive(315, 400, 1, 1, 0);
            drive(5, 20, 1, 1, 0);
            drive(315, 400, 0, 1, 0);
            tick_frame(0, 1);
        end
        check("idle_state", int'(st), 0);
        check("idle_lane0", int'(dut_lx[0]), 10);
        check("idle_lane1", int'(dut_lx[1]), 140);
        check("idle_lane2", int'(dut_lx[2]), 350);
        check("idle_lane3", int'(dut_lx[3]), 470);

        guard = 0;
        while (m_lx[0] != 639 && guard < 700) begin tick_frame(0, 0); guard++; end
        check("wrap_x639", int'(dut_lx[0]), 639);
        foreach (old[k]) old[k] = 0;
        drive(0, 60, 1, 1, 0);
        drive(90, 60, 1, 1, 0);
        drive(178, 60, 1, 1, 0);
        drive(179, 60, 1, 1, 0);
        drive(638, 60, 1, 1, 0);
        tick_frame(0, 1);
        check("wrap_x0", int'(dut_lx[0]), 0);

        do_reset("rst1");
        tick_frame(1, 1);
        check("play_start", int'(st), 1);
        guard = 0;
        while (!go && guard < 300) begin tick_frame(0, 1); guard++; end
        death_tick = ticks;
        checks++;
        if (!go || death_tick < 141 || death_tick > 142) begin
            failures++;
            $display("FAIL death_tick actual=%0d required=141..142 game_over=%0d", death_tick, go);
        end
        dead_ticks = 0;
        while (st != 2'd0 && dead_ticks < 100) begin tick_frame(0, 1); dead_ticks++; end
        check("dead_frames", dead_ticks, 60);
        check("dead_score_hold", int'(score), 0);

        tick_frame(1, 0);
        foreach (old[k]) old[k] = m_lx[k];
        tick_frame(3, 0);
        check("one_hop_score", int'(score), 1);
        for (int k = 1; k < 4; k++) check($sformatf("hop_shift%0d", k), int'(dut_lx[k]), old[k-1]);
        check("hop_seed", int'(dut_lx[0]), 225);

        for (int f = 0; f < 120; f++) tick_frame(1, 0);
        check("score_sat", int'(score), 99);
        old0 = int'(dut_lx[0]);
        tick_frame(0, 0);
        check("lvl_speed", (int'(dut_lx[0]) - old0 + 640) % 640, 5);

        drive(315, 400, 1, 1, 0);
        @(posedge clk);
        #1 probe = 1'b0;
        do_reset("rst_mid");
        repeat (3) tick_frame(0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
